// File: rtl/operand_serializer.sv
// operand_serializer: captures a frame of four WIDTH-bit operands in one
// valid/ready handshake, then streams them out one beat at a time in the
// order A, B, C, D.
// The outgoing word is picked by a Mux4to1 whose select is the beat counter.
// The next frame can be taken on the last beat, so there is no gap between
// frames and throughput is one beat per cycle.
// Optional build macro OPSER_FRAME_CNT_EN adds an 8-bit frame_cnt output.
// frame_cnt counts completed frames and wraps from 255 to 0.

module Mux4to1 #(
    parameter int INPUT_WIDTH = 8
) (
    input  logic [INPUT_WIDTH-1:0] A,
    input  logic [INPUT_WIDTH-1:0] B,
    input  logic [INPUT_WIDTH-1:0] C,
    input  logic [INPUT_WIDTH-1:0] D,
    input  logic [1:0]             S,
    output logic [INPUT_WIDTH-1:0] Y
);
    // Plain 4:1 word select
    always_comb begin
        Y = A;
        case (S)
            2'd0:    Y = A;
            2'd1:    Y = B;
            2'd2:    Y = C;
            default: Y = D;
        endcase
    end
endmodule

module operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
`ifdef OPSER_FRAME_CNT_EN
    output logic [7:0]       frame_cnt,
`endif
    output logic [1:0]       out_sel
);
    typedef enum logic {IDLE, SEND} stateT;

    stateT            stateReg, stateNext;
    logic [1:0]       selReg, selNext;
    logic [WIDTH-1:0] opA, opB, opC, opD;
    logic             loadFrame;
    logic             lastBeat;

    // On the final beat a new frame may be taken in the same cycle.
    // This gives a combinational path from out_ready to in_ready.
    assign lastBeat  = (stateReg == SEND) && (selReg == 2'd3);
    assign in_ready  = (stateReg == IDLE) || (lastBeat && out_ready);
    assign loadFrame = in_valid && in_ready;

    assign out_valid = (stateReg == SEND);
    assign out_last  = lastBeat;
    assign out_sel   = selReg;

    Mux4to1 #(.INPUT_WIDTH(WIDTH)) wordMux (
        .A(opA),
        .B(opB),
        .C(opC),
        .D(opD),
        .S(selReg),
        .Y(out_data)
    );

    // Next-state and beat-counter logic
    always_comb begin
        stateNext = stateReg;
        selNext   = selReg;
        case (stateReg)
            IDLE: begin
                if (loadFrame) begin
                    stateNext = SEND;
                    selNext   = 2'd0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (selReg != 2'd3) begin
                        selNext = selReg + 2'd1;
                    end else if (in_valid) begin
                        // Back-to-back frame: restart at beat 0 with no idle cycle.
                        selNext = 2'd0;
                    end else begin
                        stateNext = IDLE;
                        selNext   = 2'd0;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                selNext   = 2'd0;
            end
        endcase
    end

    // State and beat-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
            selReg   <= 2'd0;
        end else begin
            stateReg <= stateNext;
            selReg   <= selNext;
        end
    end

    // Operand capture, written only when a frame is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opA <= '0;
            opB <= '0;
            opC <= '0;
            opD <= '0;
        end else if (loadFrame) begin
            opA <= in_a;
            opB <= in_b;
            opC <= in_c;
            opD <= in_d;
        end
    end

`ifdef OPSER_FRAME_CNT_EN
    logic [7:0] frameCntReg;
    assign frame_cnt = frameCntReg;

    // Count frames whose last beat was accepted by the consumer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frameCntReg <= 8'd0;
        end else if (lastBeat && out_ready) begin
            frameCntReg <= frameCntReg + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_operand_serializer.sv
// Testbench for operand_serializer (16-bit build).
// The reference model is a queue of pending beats for the current frame.
// A frame is pushed as four words when it is accepted.
// One word is popped for every beat the consumer accepts.
// Each cycle the DUT outputs are compared against the model.

module tb_operand_serializer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a, in_b, in_c, in_d;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [1:0]   out_sel;
`ifdef OPSER_FRAME_CNT_EN
    logic [7:0]   frame_cnt;
`endif

    operand_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`ifdef OPSER_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    logic [W-1:0] pending[$];
    int           modelFrames = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model at the edge
    task automatic doCycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d, input logic ordy);
        logic expReady;
        @(negedge clk);
        in_valid  = iv;
        in_a = a; in_b = b; in_c = c; in_d = d;
        out_ready = ordy;
        #1;
        expReady = (pending.size() == 0) || (pending.size() == 1 && ordy);
        checkVal("in_ready", in_ready, expReady);
        checkVal("out_valid", out_valid, pending.size() != 0);
        checkVal("out_last", out_last, pending.size() == 1);
        if (pending.size() != 0) begin
            checkVal("out_data", out_data, pending[0]);
            checkVal("out_sel", out_sel, 4 - pending.size());
        end
`ifdef OPSER_FRAME_CNT_EN
        checkVal("frame_cnt", frame_cnt, modelFrames % 256);
`endif
        @(posedge clk);
        if (pending.size() != 0 && ordy) begin
            if (pending.size() == 1) modelFrames++;
            void'(pending.pop_front());
        end
        if (iv && expReady) begin
            pending.push_back(a);
            pending.push_back(b);
            pending.push_back(c);
            pending.push_back(d);
        end
    endtask

    // Reset asserted between clock edges must clear the outputs immediately
    task automatic midReset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_out_last", out_last, 0);
        checkVal("rst_out_sel", out_sel, 0);
        checkVal("rst_out_data", out_data, 0);
`ifdef OPSER_FRAME_CNT_EN
        checkVal("rst_frame_cnt", frame_cnt, 0);
`endif
        pending.delete();
        modelFrames = 0;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        #1;
        checkVal("reset_out_valid", out_valid, 0);
        checkVal("reset_out_data", out_data, 0);
        checkVal("reset_out_sel", out_sel, 0);
        checkVal("reset_out_last", out_last, 0);
        #20 rst = 1'b0;

        // Single frame with the consumer always ready
        doCycle(1, 16'h11, 16'h22, 16'h33, 16'h44, 1);
        for (int i = 0; i < 5; i++) doCycle(0, 0, 0, 0, 0, 1);

        // Stall at beat 2 for three cycles while the producer offers a frame
        doCycle(1, 16'h11, 16'h22, 16'h33, 16'h44, 1);
        doCycle(0, 0, 0, 0, 0, 1);
        doCycle(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) doCycle(1, 16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 0);
        for (int i = 0; i < 3; i++) doCycle(0, 0, 0, 0, 0, 1);

        // Back-to-back frames with in_valid held high
        doCycle(1, 1, 2, 3, 4, 1);
        for (int i = 0; i < 4; i++) doCycle(1, 5, 6, 7, 8, 1);
        for (int i = 0; i < 5; i++) doCycle(0, 0, 0, 0, 0, 1);

        // Reset while beat 1 is presented, then a fresh frame starts at beat 0
        doCycle(1, 16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD, 1);
        doCycle(0, 0, 0, 0, 0, 1);
        midReset();
        doCycle(1, 16'h00A0, 16'h00B0, 16'h00C0, 16'h00D0, 1);
        for (int i = 0; i < 5; i++) doCycle(0, 0, 0, 0, 0, 1);

        // Full-width values pass through unmodified
        doCycle(1, 16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE, 1);
        for (int i = 0; i < 5; i++) doCycle(0, 0, 0, 0, 0, 1);

        // 257 back-to-back frames exercise the frame counter wrap
        for (int f = 0; f < 257; f++) begin
            for (int k = 0; k < 4; k++)
                doCycle(1, W'(f), W'(f + 1), W'(f + 2), W'(f + 3), 1);
        end
        for (int i = 0; i < 5; i++) doCycle(0, 0, 0, 0, 0, 1);

        // Randomized handshakes on both sides
        for (int i = 0; i < 2000; i++) begin
            doCycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                    W'($urandom), W'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
